// File: rtl/bcd_segment_display_ctrl.sv
// Packed-BCD to 7-segment display controller with leading-zero blanking.
// Optional blinking is built only when the SEG_BLINK_EN macro is defined.
module bcd_segment_display_ctrl #(
  parameter int BCD_DIGITS     = 4,
  parameter int HEX_MODE       = 0,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int BLINK_TICKS    = 25000000
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [BCD_DIGITS*4-1:0] BCD_IN,
  input  logic                    BCD_VALID,
  input  logic                    LZ_BLANK_EN,
  input  logic [BCD_DIGITS-1:0]   BLINK_MASK,
  output logic [BCD_DIGITS*7-1:0] SEG_OUT,
  output logic                    UPDATE_DONE
);

  localparam int DW = BCD_DIGITS * 4;
  localparam int SW = BCD_DIGITS * 7;
  localparam logic [SW-1:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? {SW{1'b1}} : {SW{1'b0}};

  // BCD_VALID is a one-cycle strobe with no back-pressure: every sampled high
  // captures BCD_IN, and UPDATE_DONE answers it two edges later.
  logic [DW-1:0] cap_q, cap_d;
  logic          loaded_q, loaded_d;
  logic          pend_q, pend_d;
  logic [DW-1:0] disp_q, disp_d;
  logic          disp_vld_q, disp_vld_d;
  logic          upd_q, upd_d;
  logic [SW-1:0] seg_q, seg_d;
  logic          done_q, done_d;
  logic          blink_phase;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic hex;
    hex = (HEX_MODE != 0);
    case (d)
      4'h0: decode = 7'b0111111;
      4'h1: decode = 7'b0000110;
      4'h2: decode = 7'b1011011;
      4'h3: decode = 7'b1001111;
      4'h4: decode = 7'b1100110;
      4'h5: decode = 7'b1101101;
      4'h6: decode = 7'b1111101;
      4'h7: decode = 7'b0000111;
      4'h8: decode = 7'b1111111;
      4'h9: decode = 7'b1100111;
      4'hA: decode = hex ? 7'b1110111 : 7'b0000000;
      4'hB: decode = hex ? 7'b1111100 : 7'b0000000;
      4'hC: decode = hex ? 7'b0111001 : 7'b0000000;
      4'hD: decode = hex ? 7'b1011110 : 7'b0000000;
      4'hE: decode = hex ? 7'b1111001 : 7'b0000000;
      default: decode = hex ? 7'b1110001 : 7'b0000000;
    endcase
  endfunction

`ifdef SEG_BLINK_EN
  localparam int CW = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (cnt_q == CW'(BLINK_TICKS - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink_phase = phase_q;
`else
  assign blink_phase = 1'b0;
`endif

  always_comb begin
    logic       upper_zero;
    logic [3:0] dig;
    logic [6:0] raw;
    cap_d      = cap_q;
    loaded_d   = loaded_q;
    pend_d     = BCD_VALID;
    disp_d     = disp_q;
    disp_vld_d = disp_vld_q;
    upd_d      = pend_q;
    done_d     = upd_q;
    seg_d      = '0;
    upper_zero = 1'b1;
    dig        = '0;
    raw        = '0;
    if (BCD_VALID) begin
      cap_d    = BCD_IN;
      loaded_d = 1'b1;
    end
    if (pend_q) begin
      disp_d     = cap_q;
      disp_vld_d = loaded_q;
    end
    // Walk from the most significant digit so upper_zero covers digits i..top.
    for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
      dig        = disp_q[i*4 +: 4];
      upper_zero = upper_zero & (dig == 4'd0);
      raw        = decode(dig);
      if (!disp_vld_q)                           raw = 7'b0000000;
      else if (LZ_BLANK_EN && i > 0 && upper_zero) raw = 7'b0000000;
      else if (blink_phase && BLINK_MASK[i])     raw = 7'b0000000;
      seg_d[i*7 +: 7] = raw;
    end
    seg_d = seg_d ^ SEG_OFF;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cap_q      <= '0;
      loaded_q   <= 1'b0;
      pend_q     <= 1'b0;
      disp_q     <= '0;
      disp_vld_q <= 1'b0;
      upd_q      <= 1'b0;
      seg_q      <= SEG_OFF;
      done_q     <= 1'b0;
    end else begin
      cap_q      <= cap_d;
      loaded_q   <= loaded_d;
      pend_q     <= pend_d;
      disp_q     <= disp_d;
      disp_vld_q <= disp_vld_d;
      upd_q      <= upd_d;
      seg_q      <= seg_d;
      done_q     <= done_d;
    end
  end

  assign SEG_OUT     = seg_q;
  assign UPDATE_DONE = done_q;

endmodule
